pix_stream_writer: RTL



---
 rtl/pix_stream_writer_pkg.sv | 26 ++
 rtl/pix_stream_writer_if.sv | 34 +++
 rtl/pix_stream_writer_assembler.sv | 52 +++++
 rtl/pix_stream_writer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pix_stream_writer_pkg.sv
// Shared types and constants for the pixel stream writer: FSM state
// encoding, ACK/NAK reply bytes and small sizing helpers.
package pix_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HDR,
        PIX,
        CHK,
        DONE
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // Number of UART bytes that carry one stored pixel.
    function automatic int bytes_per_pix(input int pix_bits);
        return (pix_bits + 7) / 8;
    endfunction

    // Width of a counter indexing n items; never below one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_stream_writer_if.sv
// Handshake/bus bundle of the pixel stream writer. The controller side
// (uart_rx glue + system controller) uses the master modport, the writer
// block uses the slave modport.
interface pix_stream_writer_if #(
    parameter int ADDR_W   = 15,
    parameter int PIX_BITS = 12,
    parameter int ROW_W    = 8
);
    logic                i_start;
    logic                i_abort;
    logic [7:0]          i_rx_data;
    logic                i_rx_done;
    logic                o_busy;
    logic                o_wr_en;
    logic [ADDR_W-1:0]   o_wr_addr;
    logic [PIX_BITS-1:0] o_wr_data;
    logic [7:0]          o_ack_data;
    logic                o_ack_valid;
    logic [ROW_W-1:0]    o_row;
    logic                o_frame_done;
    logic                o_err;

    modport master (
        output i_start, i_abort, i_rx_data, i_rx_done,
        input  o_busy, o_wr_en, o_wr_addr, o_wr_data, o_ack_data,
               o_ack_valid, o_row, o_frame_done, o_err
    );

    modport slave (
        input  i_start, i_abort, i_rx_data, i_rx_done,
        output o_busy, o_wr_en, o_wr_addr, o_wr_data, o_ack_data,
               o_ack_valid, o_row, o_frame_done, o_err
    );
endinterface

// File: rtl/pix_stream_writer_assembler.sv
// Byte-to-pixel assembler: shifts pixel bytes in MSB first, counts bytes
// within a pixel and keeps the running XOR checksum of the row.
// pix_ready/pix_data are combinational in the strobe cycle of a pixel's
// last byte so the owner can register them into the write port.
module pix_assembler
    import pix_stream_pkg::*;
#(
    parameter int PIX_BITS = 12
) (
    input  logic                i_clk_sys,
    input  logic                i_rst_n,
    input  logic                clear,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                pix_ready,
    output logic [PIX_BITS-1:0] pix_data,
    output logic [7:0]          csum
);
    localparam int BPP   = bytes_per_pix(PIX_BITS);
    localparam int SR_W  = BPP * 8;
    localparam int CNT_W = idx_bits(BPP);

    // Only the earlier BPP-1 bytes need storing; the last byte is live.
    logic [SR_W-9:0]  shreg;
    logic [SR_W-1:0]  shreg_next;
    logic [CNT_W-1:0] byte_cnt;

    assign shreg_next = {shreg, byte_data};
    assign pix_ready  = byte_valid && (byte_cnt == CNT_W'(BPP - 1));
    // Truncation drops the unused top bits of byte 0 (e.g. 12-bit pixels).
    assign pix_data   = PIX_BITS'(shreg_next);

    // Shift register, byte counter and checksum, cleared at each row start.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg    <= '0;
            byte_cnt <= '0;
            csum     <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
            csum     <= '0;
        end else if (byte_valid) begin
            shreg    <= shreg_next[SR_W-9:0];
            csum     <= csum ^ byte_data;
            byte_cnt <= pix_ready ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pix_stream_writer.sv
// Framed pixel stream receiver: header byte, W pixels per row, XOR row
// checksum with ACK/NAK reply, linear SPRAM write port. A NAK rewinds the
// write address to the start of the row so the retransmission overwrites.
// Optional macro BYTE_TIMEOUT_EN adds an inter-byte timeout in PIX/CHK.
module pix_stream_writer
    import pix_stream_pkg::*;
#(
    parameter int         W        = 200,
    parameter int         H        = 150,
    parameter int         PIX_BITS = 12,
    parameter int         ADDR_W   = 15,
    parameter logic [7:0] HDR_BYTE = 8'hAA
`ifdef BYTE_TIMEOUT_EN
    , parameter int       TIMEOUT_CYC = 500000
`endif
) (
    input logic                i_clk_sys,
    input logic                i_rst_n,
    pix_stream_writer_if.slave bus
);
    localparam int                COL_W     = idx_bits(W);
    localparam int                ROW_W     = idx_bits(H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);

    state_t              state, state_next;
    logic                rx_ok, accept_start, pix_byte, chk_byte;
    logic                csum_ok, asm_clear, timeout, last_col, last_row;
    logic                pix_ready;
    logic [PIX_BITS-1:0] pix_data;
    logic [7:0]          csum;
    logic [COL_W-1:0]    col;
    logic [ADDR_W-1:0]   wr_ptr, row_base;

    assign rx_ok    = bus.i_rx_done && !bus.i_abort;
    assign last_col = (col == COL_W'(W - 1));
    assign last_row = (bus.o_row == ROW_W'(H - 1));
    assign csum_ok  = (bus.i_rx_data == csum);

    pix_assembler #(.PIX_BITS(PIX_BITS)) u_asm (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .clear     (asm_clear),
        .byte_valid(pix_byte),
        .byte_data (bus.i_rx_data),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .csum      (csum)
    );

`ifdef BYTE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_armed;

    assign tmo_armed = (state == PIX) || (state == CHK);
    assign timeout   = tmo_armed && !bus.i_rx_done && !bus.i_abort &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Idle-cycle counter, restarted by every byte and outside PIX/CHK.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n)                          tmo_cnt <= '0;
        else if (bus.i_rx_done || !tmo_armed)  tmo_cnt <= '0;
        else                                   tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic; abort (then timeout) overrides everything.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        if (bus.i_abort || timeout) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (bus.i_start) state_next = WAIT_HDR;
                WAIT_HDR: if (rx_ok && bus.i_rx_data == HDR_BYTE) state_next = PIX;
                PIX:      if (pix_ready && last_col) state_next = CHK;
                CHK:      if (rx_ok) state_next = (csum_ok && last_row) ? DONE : PIX;
                DONE:     state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Per-state control decodes.
    always_comb begin
        bus.o_busy   = (state != IDLE);
        accept_start = (state == IDLE) && bus.i_start && !bus.i_abort;
        pix_byte     = (state == PIX) && rx_ok;
        chk_byte     = (state == CHK) && rx_ok;
        asm_clear    = (state == IDLE) || (state == WAIT_HDR) ||
                       (state == DONE) || chk_byte;
    end

    // Write port, row/column/address tracking, ACK/NAK and error flag.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_wr_en      <= 1'b0;
            bus.o_wr_addr    <= '0;
            bus.o_wr_data    <= '0;
            bus.o_ack_data   <= 8'h00;
            bus.o_ack_valid  <= 1'b0;
            bus.o_row        <= '0;
            bus.o_frame_done <= 1'b0;
            bus.o_err        <= 1'b0;
            col              <= '0;
            wr_ptr           <= '0;
            row_base         <= '0;
        end else begin
            bus.o_wr_en      <= pix_byte && pix_ready;
            bus.o_ack_valid  <= 1'b0;
            bus.o_frame_done <= 1'b0;

            if (accept_start) begin
                bus.o_err <= 1'b0;
                bus.o_row <= '0;
                col       <= '0;
                wr_ptr    <= '0;
                row_base  <= '0;
            end

            if (pix_byte && pix_ready) begin
                bus.o_wr_addr <= wr_ptr;
                bus.o_wr_data <= pix_data;
                if (wr_ptr != LAST_ADDR) wr_ptr <= wr_ptr + 1'b1;
                col <= last_col ? '0 : col + 1'b1;
            end

            if (chk_byte) begin
                bus.o_ack_valid <= 1'b1;
                if (csum_ok) begin
                    bus.o_ack_data <= ACK_BYTE;
                    if (last_row) begin
                        bus.o_frame_done <= 1'b1;
                    end else begin
                        bus.o_row <= bus.o_row + 1'b1;
                        row_base  <= row_base + ADDR_W'(W);
                    end
                end else begin
                    bus.o_ack_data <= NAK_BYTE;
                    bus.o_err      <= 1'b1;
                    wr_ptr         <= row_base;
                    col            <= '0;
                end
            end

            if (timeout) begin
                bus.o_ack_valid <= 1'b1;
                bus.o_ack_data  <= NAK_BYTE;
                bus.o_err       <= 1'b1;
            end
        end
    end

endmodule
